// File: rtl/mm2s_axis_tx_dwc_if.sv
// Command, FIFO-read and AXI-Stream bundle for the MM2S width converter.
// master = converter side, slave = command/FIFO/sink side.
interface mm2s_axis_tx_dwc_if #(
    parameter int AXIS_DW = 32,
    parameter int RATIO   = 2,
    parameter int LEN_W   = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [LEN_W-1:0]           cmd_bytes;
    logic                       fifo_empty;
    logic [AXIS_DW*RATIO-1:0]   fifo_rdata;
    logic                       fifo_rd_en;
    logic [AXIS_DW-1:0]         m_axis_tdata;
    logic [AXIS_DW/8-1:0]       m_axis_tkeep;
    logic                       m_axis_tvalid;
    logic                       m_axis_tlast;
    logic                       m_axis_tready;
    logic                       busy;
    logic                       done;

    modport master (
        input  cmd_valid, cmd_bytes, fifo_empty, fifo_rdata, m_axis_tready,
        output cmd_ready, fifo_rd_en, m_axis_tdata, m_axis_tkeep,
        output m_axis_tvalid, m_axis_tlast, busy, done
    );

    modport slave (
        output cmd_valid, cmd_bytes, fifo_empty, fifo_rdata, m_axis_tready,
        input  cmd_ready, fifo_rd_en, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tvalid, m_axis_tlast, busy, done
    );
endinterface

// File: rtl/mm2s_axis_tx_dwc.sv
// MM2S transmit down-converter: pops wide FIFO words and streams them
// as RATIO AXI-Stream beats each, LSB lane first, with tkeep/tlast trim.
module mm2s_axis_tx_dwc #(
    parameter int AXIS_DW = 32,
    parameter int RATIO   = 2,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mm2s_axis_tx_dwc_if.master   bus
);
    localparam int BPB = AXIS_DW / 8;
    localparam int WW  = AXIS_DW * RATIO;
    localparam int LW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW  = LEN_W;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e          state_q;
    logic [WW-1:0]   word_q;
    logic            wvalid_q;
    logic [LW-1:0]   lane_q;
    logic [CW-1:0]   left_q;
    logic [CW-1:0]   unl_q;
    logic [BPB-1:0]  lkeep_q;
    logic            done_q;

    logic [LEN_W:0]   bsum;
    logic [CW-1:0]    beats_w;
    logic [LEN_W-1:0] rem_w;
    logic [BPB-1:0]   lkeep_w;
    logic             accept;
    logic             tvalid;
    logic             hs;
    logic             last_lane;
    logic             last_beat;
    logic             pop;

    assign bsum    = {1'b0, bus.cmd_bytes} + (LEN_W+1)'(BPB - 1);
    assign beats_w = CW'(bsum / (LEN_W+1)'(BPB));
    assign rem_w   = bus.cmd_bytes % LEN_W'(BPB);

    always_comb begin
        lkeep_w = '0;
        for (int i = 0; i < BPB; i++) begin
            lkeep_w[i] = (rem_w == '0) || (LEN_W'(i) < rem_w);
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) && rst_n;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign tvalid        = wvalid_q && (state_q == ACTIVE);
    assign hs            = tvalid && bus.m_axis_tready;
    assign last_lane     = (lane_q == LW'(RATIO - 1));
    assign last_beat     = (left_q == CW'(1));

    // Refill when the register is empty, or chain the next word on the
    // last lane so a ready sink sees no gap between words.
    assign pop = (state_q == ACTIVE) && !bus.fifo_empty &&
                 ((!wvalid_q && (unl_q != '0)) ||
                  (hs && last_lane && !last_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            lane_q   <= '0;
            left_q   <= '0;
            unl_q    <= '0;
            lkeep_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.cmd_bytes == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ACTIVE;
                            left_q  <= beats_w;
                            unl_q   <= beats_w;
                            lkeep_q <= lkeep_w;
                        end
                    end
                end
                ACTIVE: begin
                    if (hs) begin
                        left_q <= left_q - CW'(1);
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            lane_q   <= '0;
                            unl_q    <= '0;
                            state_q  <= IDLE;
                            done_q   <= 1'b1;
                        end else if (!last_lane) begin
                            lane_q <= lane_q + LW'(1);
                        end else if (!pop) begin
                            wvalid_q <= 1'b0;
                        end
                    end
                    if (pop) begin
                        word_q   <= bus.fifo_rdata;
                        wvalid_q <= 1'b1;
                        lane_q   <= '0;
                        unl_q    <= (unl_q > CW'(RATIO)) ?
                                    unl_q - CW'(RATIO) : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = word_q[lane_q*AXIS_DW +: AXIS_DW];
    assign bus.m_axis_tlast  = tvalid && last_beat;
    assign bus.m_axis_tkeep  = !tvalid ? '0 :
                               (last_beat ? lkeep_q : '1);
    assign bus.fifo_rd_en    = pop;
    assign bus.busy          = (state_q == ACTIVE);
    assign bus.done          = done_q;
endmodule

// File: doc/mm2s_axis_tx_dwc.md
MM2S_AXIS_TX_DWC -- requirements
Module: mm2s_axis_tx_dwc

Interface
REQ-001 SHALL have parameter AXIS_DW, default 32, AXI-Stream data width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter RATIO, default 2, AXIS beats per FIFO word (>=1).
REQ-003 SHALL have parameter LEN_W, default 16, width of the byte-count command field.
REQ-004 SHALL have port clk  input  1  clock; reset rst_n, asynchronous, active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  transfer command valid.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_bytes  input  LEN_W  total bytes in transfer.
REQ-009 SHALL have port fifo_empty  input  1  show-ahead FIFO empty.
REQ-010 SHALL have port fifo_rdata  input  AXIS_DW*RATIO  FIFO head word, valid when !fifo_empty.
REQ-011 SHALL have port fifo_rd_en  output  1  pop FIFO head this cycle.
REQ-012 SHALL have ports m_axis_tdata (AXIS_DW), m_axis_tkeep (AXIS_DW/8), m_axis_tvalid (1), m_axis_tlast (1) as outputs, and m_axis_tready (1) as input.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on transfer completion.

Function
REQ-015 SHALL define BPB=AXIS_DW/8, beats=ceil(cmd_bytes/BPB), last_keep = low (cmd_bytes mod BPB) bits set, or all ones when the remainder is 0.
REQ-016 SHALL implement states IDLE and ACTIVE; cmd_ready=1 only in IDLE; busy=1 only in ACTIVE.
REQ-017 SHALL, on command accept with cmd_bytes>0, latch beats and last_keep, enter ACTIVE next cycle.
REQ-018 SHALL, on command accept with cmd_bytes==0, stay IDLE, pop nothing, emit no beat, pulse done the next cycle.
REQ-019 SHALL hold one FIFO word in a word register with valid flag wvalid and lane index lane (0..RATIO-1).
REQ-020 SHALL assert fifo_rd_en only in ACTIVE when !fifo_empty and either (!wvalid and beats remain unloaded) or (handshake on lane RATIO-1 and that beat is not the last).
REQ-021 SHALL, on pop, load fifo_rdata into the word register, set wvalid=1, lane=0 at the next edge.
REQ-022 SHALL drive m_axis_tdata = word[lane*AXIS_DW +: AXIS_DW] (lane 0 = LSBs first), m_axis_tvalid = wvalid in ACTIVE.
REQ-023 SHALL hold tdata, tkeep, tlast and tvalid stable while tvalid && !tready.
REQ-024 SHALL assert m_axis_tlast and m_axis_tkeep=last_keep only on the final beat; all other beats tkeep all ones.
REQ-025 SHALL, on non-final handshake with lane<RATIO-1, increment lane with no pop.
REQ-026 SHALL, on handshake on lane RATIO-1 with FIFO empty, clear wvalid (one-cycle minimum bubble).
REQ-027 SHALL sustain one beat per cycle when tready=1 and FIFO is non-empty at each word boundary.
REQ-028 SHALL, on final-beat handshake, clear wvalid, discard unused lanes of the current word, return to IDLE, and pulse done in the following cycle.
REQ-029 SHALL pop exactly ceil(beats/RATIO) words per transfer, never pop on fifo_empty, and never pop in IDLE.
REQ-030 SHALL size the beat counter to hold ceil((2^LEN_W-1)/BPB) without overflow.
REQ-031 SHALL accept a new command in the cycle after the final beat (IDLE), with no other dead cycles.

Reset
REQ-032 SHALL, on rst_n low at any time including mid-transfer, immediately force IDLE, wvalid=0, lane=0, counters 0, with outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, fifo_rd_en=0, busy=0, done=0, cmd_ready=0 during reset and 1 after release.
REQ-033 SHALL, after reset release, discard any partially sent transfer; the FIFO is not re-read or rewound.

Verification
REQ-034 SHALL cover AXIS_DW=32, RATIO=2, cmd_bytes=16, tready=1, FIFO full -> 4 back-to-back beats, 2 pops, tkeep=0xF every beat, tlast on beat 4, done one cycle later.
REQ-035 SHALL cover cmd_bytes=13 -> 4 beats, last tkeep=0x1 with tlast; cmd_bytes=3 -> 1 beat, tkeep=0x7, tlast=1, 1 pop, upper lane discarded.
REQ-036 SHALL cover tready low 5 cycles mid-beat -> tdata/tkeep/tlast unchanged, no extra pop, and the sequence resumes intact.
REQ-037 SHALL cover FIFO empty at a word boundary for 3 cycles -> tvalid=0, no pop while empty, and streaming resumes with lane 0 of the next word.
REQ-038 SHALL cover cmd_bytes=0 -> no beats, no pop, done pulse next cycle; then a back-to-back command of 8 bytes is accepted in the following cycle.
REQ-039 SHALL cover rst_n asserted after beat 2 of 16 bytes -> all outputs reset immediately; a new 4-byte command after release produces 1 beat with tlast=1.
